// File: rtl/add_sub_pkg.sv
// Shared definitions for the chunked add/sub unit: FSM state encoding and
// a clog2 helper that never returns less than one bit.
// No logic of its own.

package add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width needed to count 0..n-1, clamped to at least one bit so a
    // single-chunk configuration still has a legal counter.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit ripple-carry adder slice (a + b + cin -> sum, cout).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the enclosing FSM decides when the slice output is used.
//
// Ports: a, b (W bits), cin (carry in), sum (W bits), cout (carry out of MSB).

module add_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic c;

    // Explicit ripple so the carry path length is exactly W full adders.
    always_comb begin
        c   = cin;
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock, flags on the last slice.
// Latency: operand accepted on edge t -> out_valid after edge t+WIDTH/CHUNK.
// Backpressure: result/flags held in DONE until out_ready; in_ready only in IDLE.
//
// Ports: clock, reset_n (async active-low); in_valid/in_ready with data_A,
// data_B, cin (0 = A+B, 1 = A-B); out_valid/out_ready with result,
// overflow (signed), carry_out (1 = no borrow on subtract), zero.

module chunked_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_A,
    input  logic [WIDTH-1:0] data_B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry_out,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = clog2_min1(NCHUNK);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("chunked_add_sub: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK-1:0]   sum_chunk;
    logic               cout_chunk;
    logic [WIDTH-1:0]   result_nxt;
    logic               last;
    logic               accept;

    assign last   = (cnt == CNT_W'(NCHUNK - 1));
    assign accept = in_valid & in_ready;

    // Slice mux: pick the current chunk of each operand and build the
    // result with that chunk replaced by the adder output.
    always_comb begin
        a_chunk    = '0;
        b_chunk    = '0;
        result_nxt = result;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CNT_W'(i)) begin
                a_chunk                      = a_reg[i*CHUNK +: CHUNK];
                b_chunk                      = b_reg[i*CHUNK +: CHUNK];
                result_nxt[i*CHUNK +: CHUNK] = sum_chunk;
            end
        end
    end

    add_chunk #(
        .W    (CHUNK)
    ) u_add_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .sum  (sum_chunk),
        .cout (cout_chunk)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B once here, carry-in seeds the +1.
            a_reg <= data_A;
            b_reg <= data_B ^ {WIDTH{cin}};
            carry <= cin;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            result <= result_nxt;
            carry  <= cout_chunk;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                carry_out <= cout_chunk;
                // a^b^sum at the MSB recovers the carry into the MSB.
                overflow  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ sum_chunk[CHUNK-1] ^ cout_chunk;
                zero      <= (result_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_chunked_add_sub.sv
// Directed bench for chunked_add_sub: a 32/8 instance for function, flags,
// backpressure and async reset, plus 16/16 and 16/1 instances for latency.

module tb_chunked_add_sub;

    logic        clock;
    logic        reset_n;

    // 32-bit, 8-bit chunk instance
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        carry_out;
    logic        zero;

    // 16-bit instances share inputs
    logic        in_valid16;
    logic [15:0] data_a16;
    logic [15:0] data_b16;
    logic        cin16;
    logic        out_ready16;
    logic        in_ready_w, out_valid_w, ov_w, co_w, z_w;
    logic [15:0] result_w;
    logic        in_ready_n, out_valid_n, ov_n, co_n, z_n;
    logic [15:0] result_n;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;

    chunked_add_sub #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_A    (data_a),
        .data_B    (data_b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .carry_out (carry_out),
        .zero      (zero)
    );

    chunked_add_sub #(.WIDTH(16), .CHUNK(16)) u_dut_w (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready_w),
        .data_A    (data_a16),
        .data_B    (data_b16),
        .cin       (cin16),
        .out_valid (out_valid_w),
        .out_ready (out_ready16),
        .result    (result_w),
        .overflow  (ov_w),
        .carry_out (co_w),
        .zero      (z_w)
    );

    chunked_add_sub #(.WIDTH(16), .CHUNK(1)) u_dut_n (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready_n),
        .data_A    (data_a16),
        .data_B    (data_b16),
        .cin       (cin16),
        .out_valid (out_valid_n),
        .out_ready (out_ready16),
        .result    (result_n),
        .overflow  (ov_n),
        .carry_out (co_n),
        .zero      (z_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts and ends at posedge+1. Returns cycles from accept edge to out_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                          output int cycles);
        data_a   = a;
        data_b   = b;
        cin      = m;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        cycles   = 0;
        while (!out_valid && cycles < 64) begin
            @(posedge clock); #1;
            cycles++;
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] r,
                             input logic ov, input logic co, input logic z);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".result"}, 64'(result), 64'(r));
        check({tag, ".overflow"}, 64'(overflow), 64'(ov));
        check({tag, ".carry_out"}, 64'(carry_out), 64'(co));
        check({tag, ".zero"}, 64'(zero), 64'(z));
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat_w, lat_n;
        reset_n     = 1'b1;
        in_valid    = 1'b0;
        data_a      = '0;
        data_b      = '0;
        cin         = 1'b0;
        out_ready   = 1'b0;
        in_valid16  = 1'b0;
        data_a16    = '0;
        data_b16    = '0;
        cin16       = 1'b0;
        out_ready16 = 1'b0;

        #2 reset_n = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.result", 64'(result), 64'd0);
        check("reset.flags", {61'd0, overflow, carry_out, zero}, 64'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Signed overflow on add, latency 4 for 32/8
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        check("add_ovf.latency", 64'(lat), 64'd4);
        check_out("add_ovf", 32'h8000_0000, 1'b1, 1'b0, 1'b0);
        finish_op();
        check("add_ovf.idle_valid", 64'(out_valid), 64'd0);
        check("add_ovf.idle_ready", 64'(in_ready), 64'd1);

        // 5 - 7 borrows: no carry out
        run_op(32'd5, 32'd7, 1'b1, lat);
        check_out("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        finish_op();

        // Most negative minus one: signed overflow, no borrow
        run_op(32'h8000_0000, 32'd1, 1'b1, lat);
        check_out("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        finish_op();

        // Equal operands subtract to zero
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, lat);
        check_out("sub_zero", 32'h0000_0000, 1'b0, 1'b1, 1'b1);
        finish_op();

        // Backpressure: hold for 5 cycles, a stray in_valid pulse is ignored
        run_op(32'd3, 32'd4, 1'b0, lat);
        check("bp.latency", 64'(lat), 64'd4);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                data_a   = 32'hDEAD_BEEF;
                data_b   = 32'h1111_1111;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clock); #1;
            check("bp.hold_result", 64'(result), 64'd7);
            check("bp.hold_valid", 64'(out_valid), 64'd1);
            check("bp.hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        check_out("bp", 32'd7, 1'b0, 1'b0, 1'b0);
        finish_op();
        check("bp.released_valid", 64'(out_valid), 64'd0);
        check("bp.released_ready", 64'(in_ready), 64'd1);
        check("bp.retained_result", 64'(result), 64'd7);
        run_op(32'h10, 32'h20, 1'b0, lat);
        check("bp.next_latency", 64'(lat), 64'd4);
        check_out("bp.next", 32'h30, 1'b0, 1'b0, 1'b0);
        finish_op();

        // Asynchronous reset while the counter is at 2
        data_a   = 32'h1111_1111;
        data_b   = 32'h2222_2222;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("rst_run.busy_ready", 64'(in_ready), 64'd0);
        #1 reset_n = 1'b0;
        #1;
        check("rst_run.out_valid", 64'(out_valid), 64'd0);
        check("rst_run.result", 64'(result), 64'd0);
        check("rst_run.flags", {61'd0, overflow, carry_out, zero}, 64'd0);
        check("rst_run.in_ready", 64'(in_ready), 64'd1);
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #1;
            check("rst_run.no_partial", 64'(out_valid), 64'd0);
        end
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
        check("rst_run.after_latency", 64'(lat), 64'd4);
        check_out("rst_run.after", 32'd0, 1'b0, 1'b1, 1'b1);
        finish_op();

        // 16-bit configurations: single-cycle and bit-serial
        data_a16   = 16'h7FFF;
        data_b16   = 16'h0001;
        cin16      = 1'b0;
        in_valid16 = 1'b1;
        @(posedge clock); #1;
        in_valid16 = 1'b0;
        lat_w = 99;
        lat_n = 99;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock); #1;
            if (lat_w == 99 && out_valid_w) lat_w = c;
            if (lat_n == 99 && out_valid_n) lat_n = c;
        end
        check("w16c16.latency", 64'(lat_w), 64'd1);
        check("w16c16.result", 64'(result_w), 64'h8000);
        check("w16c16.overflow", 64'(ov_w), 64'd1);
        check("w16c16.carry_out", 64'(co_w), 64'd0);
        check("w16c1.latency", 64'(lat_n), 64'd16);
        check("w16c1.result", 64'(result_n), 64'h8000);
        check("w16c1.overflow", 64'(ov_n), 64'd1);
        check("w16c1.zero", 64'(z_n), 64'd0);
        out_ready16 = 1'b1;
        @(posedge clock); #1;
        out_ready16 = 1'b0;
        check("w16.idle", {62'd0, in_ready_w, in_ready_n}, 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
